audio_source_arbiter: RTL and testbench

//  Round-robin arbiter sharing one audio sample bus between four sample sources (a..d).

---
 rtl/audio_arb_pkg.sv | 6 +
 rtl/audio_source_arbiter_if.sv | 14 +
 rtl/mux4.sv | 11 +
 rtl/rr_pick4.sv | 18 +
 rtl/audio_source_arbiter.sv | 67 ++++++
 tb/tb_audio_source_arbiter.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/audio_arb_pkg.sv
// audio_arb_pkg: shared constants and state encoding for the audio source arbiter
package audio_arb_pkg;
  localparam int NUM_SRC = 4;
  localparam int BURST_CNT_W = 4;
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
endpackage

// File: rtl/audio_source_arbiter_if.sv
// audio_source_arbiter_if: source requests/samples in, selected sample and grant status out
interface audio_source_arbiter_if #(parameter int WIDTH = 32);
  logic [3:0] req;
  logic [WIDTH-1:0] a, b, c, d;
  logic out_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0] sel;
  logic [3:0] grant;
  logic [3:0] ack;
  logic busy;
  modport slave (input req, a, b, c, d, out_ready, output out_valid, out_data, sel, grant, ack, busy);
  modport master (output req, a, b, c, d, out_ready, input out_valid, out_data, sel, grant, ack, busy);
endinterface

// File: rtl/mux4.sv
// mux4: 4:1 sample multiplexer
module mux4 #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin winner among four requests, searching upward from the one after last
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] idx
);
  // walk from lowest priority (last itself) to highest so the nearest set bit wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 4; i >= 1; i--)
      if (req[2'(last + 2'(i))]) begin
        found = 1'b1;
        idx = 2'(last + 2'(i));
      end
  end
endmodule

// File: rtl/audio_source_arbiter.sv
// audio_source_arbiter: round-robin burst arbiter putting one of four sample sources on a valid/ready bus
module audio_source_arbiter
  import audio_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic reset,
  audio_source_arbiter_if.slave bus
);
  localparam logic [BURST_CNT_W-1:0] LIM = BURST_CNT_W'(BURST - 1);
  state_t state, state_n;
  logic [3:0] grant, grant_n;
  logic [1:0] sel, sel_n, last, last_n, idx;
  logic [BURST_CNT_W-1:0] cnt, cnt_n;
  logic acked, found, hs, req_sel, rearb;
  rr_pick4 u_pick (.req(bus.req), .last(last), .found(found), .idx(idx));
  mux4 #(.WIDTH(WIDTH)) u_mux (.a(bus.a), .b(bus.b), .c(bus.c), .d(bus.d), .sel(sel), .y(bus.out_data));
  assign req_sel = bus.req[sel];
  assign bus.out_valid = (state == S_SEND) && req_sel;
  assign hs = bus.out_valid && bus.out_ready;
  assign bus.ack = hs ? 4'(1) << sel : '0;
  assign bus.grant = grant;
  assign bus.sel = sel;
  assign bus.busy = state == S_SEND;
  // a source that drops req right after an ack is done; dropping it with no prior ack is a violation
  assign rearb = (state == S_IDLE) || (hs ? cnt == LIM : (!req_sel && acked));
  // next grant, rotation pointer and burst count
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    last_n = last;
    cnt_n = cnt;
    if (rearb) begin
      state_n = found ? S_SEND : S_IDLE;
      grant_n = found ? 4'(1) << idx : '0;
      sel_n = found ? idx : sel;
      last_n = found ? idx : last;
      cnt_n = '0;
    end else if (hs) begin
      cnt_n = cnt + 1'b1;
    end else if (!req_sel) begin
      state_n = S_IDLE;
      grant_n = '0;
      cnt_n = '0;
    end
  end
  // arbiter state, cleared immediately by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      grant <= '0;
      sel <= '0;
      last <= 2'd3;
      cnt <= '0;
      acked <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      last <= last_n;
      cnt <= cnt_n;
      acked <= hs;
    end
endmodule

// File: tb/tb_audio_source_arbiter.sv
// tb_audio_source_arbiter: directed scenario tests for the audio source arbiter
module tb_audio_source_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  audio_source_arbiter_if #(.WIDTH(32)) bus ();
  audio_source_arbiter #(.WIDTH(32), .BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 4'hF;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", bus.sel); end
    reset = 1'b1;
    tick();
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", bus.grant); end
  endtask

  task automatic test_single();
    do_reset();
    bus.c = 32'hCAFE;
    bus.out_ready = 1'b1;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hCAFE) begin errors++; $display("FAIL single_data: got %h expected 0000cafe", bus.out_data); end
    checks++; if (bus.sel !== 2'd2) begin errors++; $display("FAIL single_sel: got %0d expected 2", bus.sel); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant[%0d]: got %b expected 0100", k, bus.grant); end
      checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack[%0d]: got %b expected 0100", k, bus.ack); end
      tick();
    end
    bus.req = '0;
    tick();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", bus.grant); end
  endtask

  task automatic test_round_robin();
    logic [31:0] smp [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    do_reset();
    bus.a = smp[0]; bus.b = smp[1]; bus.c = smp[2]; bus.d = smp[3];
    bus.out_ready = 1'b1;
    bus.req = 4'hF;
    tick();
    for (int n = 0; n < 20; n++) begin
      checks++; if (bus.grant !== 4'(1) << (n / 4 % 4)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, bus.grant, 4'(1) << (n / 4 % 4)); end
      checks++; if (bus.ack !== 4'(1) << (n / 4 % 4)) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", n, bus.ack, 4'(1) << (n / 4 % 4)); end
      checks++; if (bus.out_data !== smp[n / 4 % 4]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", n, bus.out_data, smp[n / 4 % 4]); end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.a = 32'hA5A5_5A5A;
    bus.out_ready = 1'b0;
    bus.req = 4'b0011;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.out_valid); end
      checks++; if (bus.out_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL bp_data[%0d]: got %h expected a5a55a5a", k, bus.out_data); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL bp_ack[%0d]: got %b expected 0000", k, bus.ack); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL bp_release_ack: got %b expected 0001", bus.ack); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL bp_burst_grant[%0d]: got %b expected 0001", k, bus.grant); end
    end
    tick();
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL bp_rotate: got %b expected 0010", bus.grant); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    bus.d = 32'hDDDD_0003;
    bus.out_ready = 1'b1;
    bus.req = 4'b1010;
    tick();
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL early_grant_b: got %b expected 0010", bus.grant); end
    tick();
    checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL early_ack2: got %b expected 0010", bus.ack); end
    tick();
    bus.req = 4'b1000;
    #1;
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL early_gap_ack: got %b expected 0000", bus.ack); end
    tick();
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL early_grant_d: got %b expected 1000", bus.grant); end
    checks++; if (bus.out_data !== 32'hDDDD_0003) begin errors++; $display("FAIL early_data_d: got %h expected dddd0003", bus.out_data); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_violation_reset();
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 4'b0001;
    tick();
    tick();
    bus.req = 4'b0000;
    #1;
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL viol_ack: got %b expected 0000", bus.ack); end
    tick();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL viol_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL viol_busy: got %b expected 0", bus.busy); end
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", bus.out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    reset = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_violation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
